mod_exp_engine: RTL and testbench
=================================

// Module: mod_exp_engine
// PURPOSE
//  Responder side of the go/done modular-exponentiation handshake: computes cypher = message^exponent mod modulus.
//  Bit-serial left-to-right square-and-multiply over an interleaved shift/add/subtract modular multiplier.
//  Sits beneath the RSA top level. Host holds go with stable operands, then waits for done and reads cypher.
// PARAMETERS
//  WIDTH  4096  operand/result width in bits (bench may override to 16)
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  go        in   1      start request (level, sampled in IDLE)
//  message   in   WIDTH  base X (any value; reduced internally)
//  exponent  in   WIDTH  exponent E
//  modulus   in   WIDTH  modulus M
//  cypher    out  WIDTH  result, valid while done=1
//  done      out  1      result ready (level)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cypher=0, done=0, all internal regs cleared.
//  Reset asserted mid-operation aborts immediately, with no partial result.
//  FSM states: IDLE, LOAD, RED, SQR, MUL, DONE.
//  IDLE: on an edge with go=1, go to LOAD. go=0 holds IDLE.
//  LOAD (1 cycle):
//   - Capture X, E and M into internal registers. Later changes to the inputs are ignored.
//   - If M<=1, set cypher=0 and go to DONE.
//   - Else set R=1 and bit index i=WIDTH-1, then go to RED.
//  Every multiply (RED, SQR, MUL) takes exactly WIDTH+1 cycles: 1 setup cycle, then WIDTH iterations.
//   - Setup: P=0, A=multiplier, B=multiplicand.
//   - Iteration, scanning A from its MSB: T = 2P + (a_k ? B : 0).
//   - Then P = T - M if T>=M; apply this reduction up to twice.
//   - Invariant P<M and B<M, hence T<3M. Hold T in WIDTH+2 bits; no overflow is permitted.
//  RED: A=X, B=1. Result Xr = X mod M (handles X>=M). Then go to SQR.
//  SQR: A=R, B=R. R=P.
//   - If E[i]=1, go to MUL.
//   - Else if i=0, go to DONE; otherwise i=i-1 and go to SQR.
//  MUL: A=R, B=Xr. R=P.
//   - If i=0, go to DONE; otherwise i=i-1 and go to SQR.
//  Leading zero exponent bits are not skipped; the latency is data-dependent only through popcount(E).
//  Latency from the edge sampling go in IDLE to the edge raising done:
//   - M>1: 2 + (WIDTH+1)*(1 + WIDTH + popcount(E)).
//   - M<=1: 2.
//  DONE:
//   - cypher=R is registered on entry (0 when M<=1) and held stable. done=1.
//   - Stay in DONE while go=1.
//   - On go=0, done falls on the next edge and the FSM returns to IDLE. cypher keeps its last value.
//   - A new job requires go to be low for at least 1 cycle, then high again.
//  E=0, M>1: every step is a square of 1, so cypher=1.
//  X=0: cypher=0, unless E=0, in which case cypher=1 (0^0 is defined as 1).
//  Outputs are registered only; there are no combinational paths from inputs to outputs.
// TESTING
//  T1: WIDTH=16, X=0x32, E=37, M=77 -> cypher=8; done rises exactly 342 edges after go is sampled.
//  T2: X=8, E=13, M=77 -> cypher=50 (0x32); the round trip of T1 is confirmed.
//  T3: X=127 (X>=M), E=1, M=77 -> cypher=50. Also E=0, M=77 -> cypher=1.
//  T4: M=1 and M=0 with any X, E -> cypher=0; done rises 2 edges after go is sampled.
//  T5: Change X/E/M after LOAD -> result is unchanged. Hold go=1 after done -> done stays 1, no restart.
//      Drop go -> done=0 next edge. Re-raise go -> a new job runs.
//  T6: Assert reset mid-SQR -> done=0 and cypher=0 immediately (async).
//      Release reset, re-run T1 -> cypher=8 with correct latency.

Source files
------------

// File: rtl/mod_exp_engine.sv
// Modular exponentiation responder: cypher = message^exponent mod modulus, computed with
// left-to-right square-and-multiply over a bit-serial interleaved modular multiplier.
module mod_exp_engine #(
    parameter int WIDTH = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cypher,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RED  = 3'd2,
        S_SQR  = 3'd3,
        S_MUL  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, e_q, e_d, m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d, xr_q, xr_d;
    logic [WIDTH-1:0] p_q, p_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] cypher_q, cypher_d;
    logic             done_q, done_d;
    logic [IW-1:0]    i_q, i_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One multiplier iteration: T = 2P + (a ? B : 0) < 3M, so at most two subtractions bring it below M.
    logic [WIDTH+1:0] m_ext, t0, t1, t2;
    logic [WIDTH-1:0] p_step;

    always_comb begin
        m_ext  = {2'b00, m_q};
        t0     = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        t1     = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2     = (t1 >= m_ext) ? (t1 - m_ext) : t1;
        p_step = t2[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        xr_d     = xr_q;
        p_d      = p_q;
        a_d      = a_q;
        b_d      = b_q;
        cypher_d = cypher_q;
        done_d   = done_q;
        i_d      = i_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LOAD;
            end
            S_LOAD: begin
                x_d = message;
                e_d = exponent;
                m_d = modulus;
                if (modulus <= WIDTH'(1)) begin
                    cypher_d = '0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    r_d     = WIDTH'(1);
                    i_d     = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    state_d = S_RED;
                end
            end
            S_RED, S_SQR, S_MUL: begin
                if (cnt_q == '0) begin
                    p_d   = '0;
                    cnt_d = CW'(1);
                    case (state_q)
                        S_RED: begin
                            a_d = x_q;
                            b_d = WIDTH'(1);
                        end
                        S_SQR: begin
                            a_d = r_q;
                            b_d = r_q;
                        end
                        default: begin
                            a_d = r_q;
                            b_d = xr_q;
                        end
                    endcase
                end else begin
                    p_d   = p_step;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH)) begin
                        // Final iteration: consume the product directly so each multiply is WIDTH+1 cycles.
                        cnt_d = '0;
                        if (state_q == S_RED) begin
                            xr_d    = p_step;
                            state_d = S_SQR;
                        end else begin
                            r_d = p_step;
                            if (state_q == S_SQR && e_q[i_q]) begin
                                state_d = S_MUL;
                            end else if (i_q == '0) begin
                                cypher_d = p_step;
                                done_d   = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                i_d     = i_q - IW'(1);
                                state_d = S_SQR;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (!go) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            xr_q     <= '0;
            p_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cypher_q <= '0;
            done_q   <= 1'b0;
            i_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            xr_q     <= xr_d;
            p_q      <= p_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cypher_q <= cypher_d;
            done_q   <= done_d;
            i_q      <= i_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cypher    = cypher_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine at WIDTH=16: directed jobs, expected cypher queued by the driver
// and checked by a monitor on each rising done; latency and handshake checked by the driver.
module tb_mod_exp_engine;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         go;
  logic [W-1:0] message;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic [W-1:0] cypher;
  logic         done;
  logic [2:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic         done_prev = 1'b0;

  mod_exp_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .message   (message),
    .exponent  (exponent),
    .modulus   (modulus),
    .cypher    (cypher),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  // monitor: pop and compare on every rising done
  always @(negedge clk) begin
    if (reset && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL cypher_unexpected: got %0d expected no result at %0t", cypher, $time);
      end else begin
        check("cypher", cypher, exp_q.pop_front());
      end
    end
    done_prev = done;
  end

  function automatic int lat_of(input logic [W-1:0] e, input logic [W-1:0] m);
    if (m <= 1) return 2;
    return 2 + (W + 1) * (1 + W + $countones(e));
  endfunction

  // driver: one full go/done job
  task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] m,
                         input logic [W-1:0] exp_c, input int exp_lat, input bit mutate,
                         input int hold);
    int  n;
    bit  seen;
    @(negedge clk);
    message  = x;
    exponent = e;
    modulus  = m;
    go       = 1'b1;
    exp_q.push_back(exp_c);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      if (mutate && n == 3) begin
        message  = W'($urandom_range(0, 65535));
        exponent = W'($urandom_range(0, 65535));
        modulus  = W'($urandom_range(0, 65535));
      end
      seen = done;
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done expected done after %0d edges", exp_lat);
      void'(exp_q.pop_back());
    end else begin
      check("latency", n, exp_lat);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_cypher", cypher, exp_c);
    end
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("done_drop", {31'd0, done}, 32'd0);
    check("back_idle", state_dbg, 32'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    go       = 1'b0;
    message  = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cypher", cypher, 32'd0);
    check("rst_state", state_dbg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T1, T2, T3
    run_job(16'h0032, 16'd37, 16'd77, 16'd8, 342, 1'b0, 0);
    run_job(16'd8, 16'd13, 16'd77, 16'd50, lat_of(16'd13, 16'd77), 1'b0, 0);
    run_job(16'd127, 16'd1, 16'd77, 16'd50, lat_of(16'd1, 16'd77), 1'b0, 0);
    run_job(16'h0032, 16'd0, 16'd77, 16'd1, 291, 1'b0, 0);
    run_job(16'd0, 16'd0, 16'd77, 16'd1, 291, 1'b0, 0);
    run_job(16'd0, 16'd5, 16'd77, 16'd0, lat_of(16'd5, 16'd77), 1'b0, 0);
    // T4
    run_job(16'h1234, 16'h0055, 16'd1, 16'd0, 2, 1'b0, 0);
    run_job(16'hBEEF, 16'hFFFF, 16'd0, 16'd0, 2, 1'b0, 0);
    // extra patterns and wide-modulus boundaries
    run_job(16'd3, 16'd4, 16'd7, 16'd4, lat_of(16'd4, 16'd7), 1'b0, 0);
    run_job(16'd2, 16'd10, 16'd1000, 16'd24, lat_of(16'd10, 16'd1000), 1'b0, 0);
    run_job(16'd2, 16'd16, 16'hFFFF, 16'd1, 308, 1'b0, 0);
    run_job(16'hFFFF, 16'd2, 16'hFFFE, 16'd1, lat_of(16'd2, 16'hFFFE), 1'b0, 0);
    // T5: inputs disturbed after LOAD, go held after done
    run_job(16'd8, 16'd13, 16'd77, 16'd50, lat_of(16'd13, 16'd77), 1'b1, 5);

    // T6: asynchronous abort during a square
    @(negedge clk);
    message  = 16'h0032;
    exponent = 16'd37;
    modulus  = 16'd77;
    go       = 1'b1;
    n = 0;
    while (state_dbg != 3'd3 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("reach_sqr", state_dbg, 32'd3);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_cypher", cypher, 32'd0);
    check("abort_state", state_dbg, 32'd0);
    go = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(16'h0032, 16'd37, 16'd77, 16'd8, 342, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
